// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter
// Brief  : 68000 BR/BG/BGACK bus-mastership sequencer with round-robin grant
//          to NREQ on-board requesters and an optional tenure limit.
// Rev    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int NREQ       = 2,
    parameter int MAX_TENURE = 256
) (
    input  logic            clk,
    input  logic            por_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            preempt,
    output logic            busy,
    input  logic            bg_n,
    input  logic            as_n,
    input  logic            dtack_n,
    input  logic            bgack_in_n,
    output logic            br_n,
    output logic            bgack_n
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OWN  = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;

    localparam logic [CW-1:0] c_CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0] c_CNT_LAST = CW'(MAX_TENURE - 1);
    localparam logic [IW-1:0] c_PTR_RST  = IW'(NREQ - 1);

    logic [2:0]      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_win;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_gnt;
    logic            r_preempt;
    logic            r_busy;
    logic            r_br_n;
    logic            r_bgack_n;

    logic [2:0]      w_nxt;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic            w_go;
    logic            w_hit;
    int              w_idx;
    logic [IW-1:0]   w_win_nxt;
    logic [IW-1:0]   w_ptr_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic            w_preempt_nxt;
    logic            w_busy_nxt;
    logic            w_br_n_nxt;
    logic            w_bgack_n_nxt;

    // State and all Moore outputs are registered together.
    always_ff @(posedge clk or negedge por_n) begin
        if (!por_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_PTR_RST;
            r_win     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_preempt <= 1'b0;
            r_busy    <= 1'b0;
            r_br_n    <= 1'b1;
            r_bgack_n <= 1'b1;
        end else begin
            r_state   <= w_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_preempt <= w_preempt_nxt;
            r_busy    <= w_busy_nxt;
            r_br_n    <= w_br_n_nxt;
            r_bgack_n <= w_bgack_n_nxt;
        end
    end

    always_comb begin
        w_pick  = r_ptr;
        w_found = 1'b0;
        w_idx   = 0;
        // Scan starts one past the last owner so it gets lowest priority.
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req[IW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = IW'(w_idx);
            end
        end

        w_go  = !bg_n && as_n && dtack_n && bgack_in_n;
        w_hit = (MAX_TENURE != 0) && (r_cnt == c_CNT_LAST);

        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (|req) w_nxt = S_REQ;
            S_REQ: begin
                if (!(|req)) begin
                    w_nxt = S_IDLE;
                end else if (!bg_n) begin
                    w_nxt = S_WAIT;
                end
            end
            S_WAIT: if (w_go) w_nxt = w_found ? S_OWN : S_IDLE;
            S_OWN:  if (!req[r_win] || w_hit) w_nxt = S_REL;
            S_REL:  w_nxt = (|req) ? S_REQ : S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_win_nxt = (r_state == S_WAIT && w_go && w_found) ? w_pick : r_win;
        w_ptr_nxt = (r_state == S_REL) ? r_win : r_ptr;

        w_cnt_nxt = r_cnt;
        if (r_state == S_OWN) begin
            if (r_cnt != c_CNT_SAT) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else if (r_state == S_REL) begin
            w_cnt_nxt = '0;
        end

        w_gnt_nxt = '0;
        if (w_nxt == S_OWN) begin
            w_gnt_nxt[w_win_nxt] = 1'b1;
        end

        // A requester that drops in the limit cycle is a plain release.
        w_preempt_nxt = (r_state == S_OWN) && req[r_win] && w_hit;
        w_busy_nxt    = (w_nxt != S_IDLE);
        w_br_n_nxt    = !((w_nxt == S_REQ) || (w_nxt == S_WAIT));
        w_bgack_n_nxt = (w_nxt != S_OWN);
    end

    assign gnt     = r_gnt;
    assign preempt = r_preempt;
    assign busy    = r_busy;
    assign br_n    = r_br_n;
    assign bgack_n = r_bgack_n;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Scoreboard bench for bus_arbiter; grant-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int NREQ = 2;
    localparam int MAXT = 8;

    logic            clk = 1'b0;
    logic            por_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            preempt;
    logic            busy;
    logic            bg_n;
    logic            as_n;
    logic            dtack_n;
    logic            bgack_in_n;
    logic            br_n;
    logic            bgack_n;

    bus_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAXT)) dut (
        .clk        (clk),
        .por_n      (por_n),
        .req        (req),
        .gnt        (gnt),
        .preempt    (preempt),
        .busy       (busy),
        .bg_n       (bg_n),
        .as_n       (as_n),
        .dtack_n    (dtack_n),
        .bgack_in_n (bgack_in_n),
        .br_n       (br_n),
        .bgack_n    (bgack_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] g;
        int              len;
        int              pre;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ptr_m  = NREQ - 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Round-robin: first requester after the previous owner, wrapping.
    function automatic int pick(input logic [NREQ-1:0] m);
        for (int i = 1; i <= NREQ; i++) begin
            int idx = (ptr_m + i) % NREQ;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic expect_grant(input int w, input int h);
        exp_t e;
        e.g    = '0;
        e.g[w] = 1'b1;
        e.len  = (MAXT != 0 && h > MAXT) ? MAXT : h;
        e.pre  = (MAXT != 0 && h > MAXT) ? 1 : 0;
        sb.push_back(e);
        ptr_m = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check("idle_busy", int'(busy), 0);
        check("idle_br_n", int'(br_n), 1);
        check("idle_gnt", int'(gnt), 0);
    endtask

    // One bus tenure: request mask m, owner holds h grant cycles, bg_n low
    // at step tb, bus blocked by signal blk until step b (b=0: not blocked).
    task automatic do_txn(input logic [NREQ-1:0] m, input int h, input int tb,
                          input int b, input int blk);
        int t;
        int k;
        int cyc;
        expect_grant(pick(m), h);
        k = (tb + 2 > b + 1) ? tb + 2 : b + 1;
        req  = m;
        bg_n = 1'b1;
        if (b > 0) begin
            case (blk)
                0:       as_n       = 1'b0;
                1:       dtack_n    = 1'b0;
                default: bgack_in_n = 1'b0;
            endcase
        end
        t = 0;
        while (t < k + 10) begin
            step();
            t++;
            if (t == 1) begin
                check("br_n_in_req", int'(br_n), 0);
                check("busy_in_req", int'(busy), 1);
            end
            if (gnt != '0) break;
            if (t == tb) bg_n = 1'b0;
            if (t == b) begin
                as_n       = 1'b1;
                dtack_n    = 1'b1;
                bgack_in_n = 1'b1;
            end
        end
        check("grant_latency", t, k);
        check("grant_seen", int'(gnt != '0), 1);
        if (h <= MAXT) begin
            cyc = 1;
            while (cyc < h) begin
                step();
                cyc++;
            end
            req  = '0;
            bg_n = 1'b1;
        end else begin
            cyc = 0;
            while (gnt != '0 && cyc < MAXT + 5) begin
                step();
                cyc++;
            end
            step();
            check("rerequest_br_n", int'(br_n), 0);
            check("rerequest_busy", int'(busy), 1);
            req  = '0;
            bg_n = 1'b1;
        end
        as_n       = 1'b1;
        dtack_n    = 1'b1;
        bgack_in_n = 1'b1;
        wait_idle();
    endtask

    int run_len = 0;
    logic [NREQ-1:0] run_g = '0;

    always @(negedge clk) begin
        if (!por_n) begin
            run_len = 0;
        end else begin
            check("gnt_onehot0", int'($countones(gnt) <= 1), 1);
            check("bgack_n_vs_gnt", int'(bgack_n), int'(gnt == '0));
            if (gnt != '0) begin
                if (run_len == 0) begin
                    run_g   = gnt;
                    run_len = 1;
                end else begin
                    check("gnt_stable", int'(gnt), int'(run_g));
                    run_len++;
                end
                check("br_n_in_own", int'(br_n), 1);
            end else if (run_len > 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", int'(run_g), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("grant_winner", int'(run_g), int'(mon_e.g));
                    check("grant_len", run_len, mon_e.len);
                    check("preempt_at_rel", int'(preempt), mon_e.pre);
                end
                run_len = 0;
            end else begin
                check("preempt_idle", int'(preempt), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ws[4];
        int n;
        logic [NREQ-1:0] m;

        por_n = 1'b0; req = '0; bg_n = 1'b1;
        as_n = 1'b1; dtack_n = 1'b1; bgack_in_n = 1'b1;
        repeat (3) step();
        check("rst_br_n", int'(br_n), 1);
        check("rst_bgack_n", int'(bgack_n), 1);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_preempt", int'(preempt), 0);
        por_n = 1'b1;
        step();

        // Request withdrawn before the CPU grants.
        req = 'b1;
        step();
        check("wd_br_n_low", int'(br_n), 0);
        req = '0;
        step();
        check("wd_br_n_high", int'(br_n), 1);
        check("wd_busy", int'(busy), 0);
        repeat (3) begin
            step();
            check("wd_no_gnt", int'(gnt), 0);
        end

        // Continuous contention: both requesting, each owner releases after 3.
        for (int g = 0; g < 4; g++) begin
            ws[g] = pick(NREQ'(3));
            expect_grant(ws[g], 3);
        end
        req  = NREQ'(3);
        bg_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (gnt == '0 && n < 20) begin
                step();
                n++;
            end
            check("rr_grant_seen", int'(gnt != '0), 1);
            step();
            step();
            m = NREQ'(3);
            m[ws[g]] = 1'b0;
            req = m;
            step();
            if (g < 3) begin
                req = NREQ'(3);
            end else begin
                req  = '0;
                bg_n = 1'b1;
            end
        end
        wait_idle();

        do_txn(NREQ'(1), 2, 2, 0, 0);
        do_txn(NREQ'(1), 3, 1, 5, 0);
        do_txn(NREQ'(2), 2, 1, 4, 2);
        do_txn(NREQ'(3), 1, 2, 6, 1);
        do_txn(NREQ'(1), 12, 1, 0, 0);
        do_txn(NREQ'(1), MAXT, 1, 0, 0);

        for (int r = 0; r < 30; r++) begin
            do_txn(NREQ'($urandom_range(1, 3)), int'($urandom_range(1, 11)),
                   int'($urandom_range(1, 3)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)));
        end

        // Asynchronous reset in the middle of a tenure.
        req  = NREQ'(1);
        bg_n = 1'b0;
        n = 0;
        while (gnt == '0 && n < 20) begin
            step();
            n++;
        end
        check("pre_reset_gnt", int'(gnt), 1);
        step();
        #2;
        por_n = 1'b0;
        #1;
        check("arst_br_n", int'(br_n), 1);
        check("arst_bgack_n", int'(bgack_n), 1);
        check("arst_gnt", int'(gnt), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_preempt", int'(preempt), 0);
        req  = '0;
        bg_n = 1'b1;
        step();
        step();
        por_n = 1'b1;
        ptr_m = NREQ - 1;
        step();

        do_txn(NREQ'(3), 2, 1, 0, 0);

        repeat (5) step();
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
